// File: rtl/regfile_wb_buffer_pkg.sv
// Shared TinyRV1 register-file types and constants for the write-back path.
package regfile_wb_buffer_pkg;

  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned RF_DATA_W = 32;
  localparam logic [RF_ADDR_W-1:0] RF_ZERO_REG = 5'd0;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } rf_wr_t;

endpackage

// File: rtl/regfile_wb_queue.sv
// Circular FIFO of pending register writes; exposes every slot and a valid mask
// so the parent can search all in-flight writes for read forwarding.
module regfile_wb_queue
  import regfile_wb_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  rf_wr_t                     push_ent,
  input  logic                       pop,
  output rf_wr_t                     head_ent,
  output rf_wr_t                     ents [DEPTH],
  output logic [DEPTH-1:0]           valid,
  output logic [$clog2(DEPTH)-1:0]   head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  rf_wr_t           mem_q [DEPTH];
  rf_wr_t           mem_d [DEPTH];
  logic [PTR_W-1:0] age;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    mem_d   = mem_q;
    if (push) begin
      mem_d[tail_q] = push_ent;
      tail_d        = tail_q + PTR_W'(1);
    end
    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Slot contents need no reset; the valid mask hides stale entries.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    age   = '0;
    valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age      = PTR_W'(i) - head_q;
      valid[i] = CNT_W'(age) < count_q;
    end
  end

  assign head_ent = mem_q[head_q];
  assign ents     = mem_q;
  assign head     = head_q;
  assign count    = count_q;

endmodule

// File: rtl/regfile_wb_buffer.sv
// Write-back buffer in front of the 1r1w zero-register regfile: queues writes,
// drains one per granted cycle, and forwards the youngest pending value to reads.
module regfile_wb_buffer
  import regfile_wb_buffer_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = RF_ADDR_W,
  parameter int unsigned DATA_W = RF_DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_val,
  output logic                     in_rdy,
  input  logic [ADDR_W-1:0]        in_waddr,
  input  logic [DATA_W-1:0]        in_wdata,
  input  logic                     rf_gnt,
  output logic                     rf_wen,
  output logic [ADDR_W-1:0]        rf_waddr,
  output logic [DATA_W-1:0]        rf_wdata,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic [ADDR_W-1:0]        rf_raddr,
  input  logic [DATA_W-1:0]        rf_rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  rf_wr_t           push_ent;
  rf_wr_t           head_ent;
  rf_wr_t           ents [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PTR_W-1:0] head;
  logic [CNT_W-1:0] count_w;
  logic             push;
  logic             pop;
  logic             empty;
  logic             hit;
  logic [PTR_W-1:0] age;
  logic [PTR_W-1:0] best_age;
  logic [DATA_W-1:0] fwd_data;

  // Writes to x0 complete the handshake but are never stored.
  assign empty         = (count_w == '0);
  assign in_rdy        = (count_w != CNT_W'(DEPTH));
  assign push          = in_val && in_rdy && (RF_ADDR_W'(in_waddr) != RF_ZERO_REG);
  assign pop           = !empty && rf_gnt;
  assign push_ent.addr = RF_ADDR_W'(in_waddr);
  assign push_ent.data = RF_DATA_W'(in_wdata);

  regfile_wb_queue #(.DEPTH(DEPTH)) u_queue (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_ent (push_ent),
    .pop      (pop),
    .head_ent (head_ent),
    .ents     (ents),
    .valid    (valid),
    .head     (head),
    .count    (count_w)
  );

  assign rf_wen   = pop;
  assign rf_waddr = ADDR_W'(head_ent.addr);
  assign rf_wdata = DATA_W'(head_ent.data);
  assign rf_raddr = rd_addr;
  assign count    = count_w;

  // Youngest match wins: largest distance from head among valid matching slots.
  always_comb begin
    hit      = 1'b0;
    age      = '0;
    best_age = '0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age = PTR_W'(i) - head;
      if (valid[i] && (ents[i].addr == RF_ADDR_W'(rd_addr)) && (!hit || (age > best_age))) begin
        hit      = 1'b1;
        best_age = age;
        fwd_data = DATA_W'(ents[i].data);
      end
    end
    if (RF_ADDR_W'(rd_addr) == RF_ZERO_REG) begin
      rd_data = '0;
    end else if (hit) begin
      rd_data = fwd_data;
    end else begin
      rd_data = rf_rdata;
    end
  end

endmodule

// File: tb/tb_regfile_wb_buffer.sv
// Randomised and directed bench for regfile_wb_buffer against a queue-plus-array reference model.
module tb_regfile_wb_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_val;
  logic        in_rdy;
  logic [4:0]  in_waddr;
  logic [31:0] in_wdata;
  logic        rf_gnt;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic [2:0]  count;

  regfile_wb_buffer #(.DEPTH(DEPTH), .ADDR_W(5), .DATA_W(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_val   (in_val),
    .in_rdy   (in_rdy),
    .in_waddr (in_waddr),
    .in_wdata (in_wdata),
    .rf_gnt   (rf_gnt),
    .rf_wen   (rf_wen),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rf_raddr (rf_raddr),
    .rf_rdata (rf_rdata),
    .count    (count)
  );

  always #5 clk = ~clk;

  // Environment regfile driven by the DUT write port.
  logic [31:0] rf_mem [32];
  assign rf_rdata = rf_mem[rf_raddr];
  always @(posedge clk) begin
    if (rf_wen && rf_waddr != 5'd0) rf_mem[rf_waddr] <= rf_wdata;
  end

  // Reference model: ordered list of pending writes plus the architectural regfile.
  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;
  ent_t        mq[$];
  logic [31:0] gold_rf [32];

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].a == a) return mq[i].d;
    end
    return gold_rf[a];
  endfunction

  // One cycle: apply inputs at negedge, check settled outputs, then advance the model at posedge.
  task automatic step(input logic v, input logic [4:0] wa, input logic [31:0] wd,
                      input logic g, input logic [4:0] ra);
    logic exp_rdy, exp_wen;
    @(negedge clk);
    in_val = v; in_waddr = wa; in_wdata = wd; rf_gnt = g; rd_addr = ra;
    #1;
    exp_rdy = (mq.size() < DEPTH);
    exp_wen = (mq.size() > 0) && g;
    chk("count",    32'(count),    32'(mq.size()));
    chk("in_rdy",   32'(in_rdy),   32'(exp_rdy));
    chk("rf_wen",   32'(rf_wen),   32'(exp_wen));
    chk("rf_raddr", 32'(rf_raddr), 32'(ra));
    chk("rd_data",  rd_data,       model_read(ra));
    if (exp_wen) begin
      chk("rf_waddr", 32'(rf_waddr), 32'(mq[0].a));
      chk("rf_wdata", rf_wdata,      mq[0].d);
    end
    @(posedge clk);
    if (exp_wen) begin
      gold_rf[mq[0].a] = mq[0].d;
      void'(mq.pop_front());
    end
    if (v && exp_rdy && wa != 5'd0) mq.push_back('{a: wa, d: wd});
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      rf_mem[i]  = 32'd0;
      gold_rf[i] = 32'd0;
    end
    reset = 1'b1; in_val = 1'b0; in_waddr = '0; in_wdata = '0; rf_gnt = 1'b0; rd_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd3);

    // Mid-cycle reset with three pending writes drops them all.
    step(1'b1, 5'd9,  32'h900, 1'b0, 5'd9);
    step(1'b1, 5'd10, 32'hA00, 1'b0, 5'd9);
    step(1'b1, 5'd11, 32'hB00, 1'b0, 5'd10);
    @(negedge clk);
    in_val = 1'b0; rf_gnt = 1'b1; rd_addr = 5'd9;
    #2 reset = 1'b1;
    #1;
    mq.delete();
    chk("rst_count",  32'(count),  32'd0);
    chk("rst_in_rdy", 32'(in_rdy), 32'd1);
    chk("rst_rf_wen", 32'(rf_wen), 32'd0);
    chk("rst_rd_data", rd_data,    gold_rf[9]);
    @(negedge clk);
    reset = 1'b0;

    // Single write, immediate drain, then read back from the regfile.
    step(1'b1, 5'd5, 32'hdead, 1'b1, 5'd5);
    step(1'b0, 5'd0, 32'd0,    1'b1, 5'd5);
    step(1'b0, 5'd0, 32'd0,    1'b1, 5'd5);
    chk("rf5", rf_mem[5], 32'hdead);

    // Fill while the port is busy, stall a fifth request, then drain in order.
    step(1'b1, 5'd1, 32'ha, 1'b0, 5'd2);
    step(1'b1, 5'd2, 32'hb, 1'b0, 5'd2);
    step(1'b1, 5'd3, 32'hc, 1'b0, 5'd1);
    step(1'b1, 5'd4, 32'hd, 1'b0, 5'd4);
    step(1'b1, 5'd6, 32'he, 1'b0, 5'd6);
    step(1'b1, 5'd6, 32'he, 1'b1, 5'd3);
    for (int i = 0; i < 5; i++) step(1'b0, 5'd0, 32'd0, 1'b1, 5'(i + 1));
    chk("rf4", rf_mem[4], 32'hd);

    // Two pending writes to one register: youngest forwards, last one lands.
    step(1'b1, 5'd7, 32'h11, 1'b0, 5'd7);
    step(1'b1, 5'd7, 32'h22, 1'b0, 5'd7);
    step(1'b0, 5'd0, 32'd0,  1'b0, 5'd7);
    for (int i = 0; i < 3; i++) step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
    chk("rf7", rf_mem[7], 32'h22);

    // Writes to x0 are accepted but discarded.
    step(1'b1, 5'd0, 32'hffff, 1'b1, 5'd0);
    step(1'b0, 5'd0, 32'd0,    1'b1, 5'd0);

    // Random traffic with a small address range to force collisions.
    for (int c = 0; c < 200; c++) begin
      step(($urandom_range(0, 9) < 7), 5'($urandom_range(0, 7)), $urandom(),
           ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)));
    end
    for (int c = 0; c < 6; c++) step(1'b0, 5'd0, 32'd0, 1'b1, 5'($urandom_range(0, 7)));
    for (int i = 1; i < 8; i++) chk("rf_final", rf_mem[i], gold_rf[i]);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
